fib_request_controller: RTL and testbench

Request/response sequencer for the Fibonacci datapath. Accepts an index n over a valid/ready request channel and steps an internal two-register Fibonacci engine n times. Returns F(n) (F(0)=0, F(1)=1) with an overflow flag over a valid/ready response channel. One request in flight at a time; sits between a software/host requester and the Fibonacci arithmetic.

---
 rtl/fib_pkg.sv | 14 +
 rtl/fib_step_engine.sv | 49 ++++
 rtl/fib_request_controller.sv | 121 ++++++++++++
 tb/tb_fib_request_controller.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fib_pkg.sv
// Shared types and default widths for the Fibonacci request controller.
package fib_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fib_state_e;

    localparam int FIB_DATA_WIDTH  = 32;
    localparam int FIB_INDEX_WIDTH = 8;
    localparam int FIB_COUNT_WIDTH = 16;

endpackage

// File: rtl/fib_step_engine.sv
// Two-register Fibonacci engine: a holds F(k), b holds F(k+1).
// Each register carries a sticky flag that is set once its true value
// has exceeded DATA_WIDTH bits, so a's flag describes exactly the value
// in a and is never polluted by an overflow of the look-ahead term b.
module fib_step_engine
    import fib_pkg::*;
#(
    parameter int DATA_WIDTH = FIB_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_load,
    input  logic                  i_step,
    output logic [DATA_WIDTH-1:0] o_a,
    output logic                  o_a_ovf
);

    logic [DATA_WIDTH-1:0] r_a;
    logic [DATA_WIDTH-1:0] r_b;
    logic                  r_a_ovf;
    logic                  r_b_ovf;
    logic [DATA_WIDTH:0]   w_sum;

    assign w_sum = {1'b0, r_a} + {1'b0, r_b};

    // Load restarts the sequence at F(0)/F(1); step advances it by one.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_a     <= '0;
            r_b     <= DATA_WIDTH'(1);
            r_a_ovf <= 1'b0;
            r_b_ovf <= 1'b0;
        end else if (i_load) begin
            r_a     <= '0;
            r_b     <= DATA_WIDTH'(1);
            r_a_ovf <= 1'b0;
            r_b_ovf <= 1'b0;
        end else if (i_step) begin
            r_a     <= r_b;
            r_a_ovf <= r_b_ovf;
            r_b     <= w_sum[DATA_WIDTH-1:0];
            r_b_ovf <= r_b_ovf | w_sum[DATA_WIDTH];
        end
    end

    assign o_a     = r_a;
    assign o_a_ovf = r_a_ovf;

endmodule

// File: rtl/fib_request_controller.sv
// Request/response sequencer around the Fibonacci step engine.
// One request in flight; the result is held until the consumer takes it.
//
//  state | meaning
//  IDLE  | ready for a request, engine idle
//  RUN   | stepping the engine, cnt steps remaining
//  DONE  | result presented on rsp_*, waiting for rsp_ready
module fib_request_controller
    import fib_pkg::*;
#(
    parameter int DATA_WIDTH  = FIB_DATA_WIDTH,
    parameter int INDEX_WIDTH = FIB_INDEX_WIDTH,
    parameter int COUNT_WIDTH = FIB_COUNT_WIDTH
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [INDEX_WIDTH-1:0] req_index,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [DATA_WIDTH-1:0]  rsp_data,
    output logic                   rsp_overflow,
    input  logic                   abort,
    output logic                   busy,
    output logic [COUNT_WIDTH-1:0] done_count
);

    fib_state_e             r_state;
    fib_state_e             w_next;
    logic [INDEX_WIDTH-1:0] r_cnt;
    logic [DATA_WIDTH-1:0]  r_rsp_data;
    logic                   r_rsp_ovf;
    logic [COUNT_WIDTH-1:0] r_done_count;
    logic                   w_load;
    logic                   w_step;
    logic                   w_capture;
    logic                   w_rsp_fire;
    logic [DATA_WIDTH-1:0]  w_a;
    logic                   w_a_ovf;

    fib_step_engine #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_engine (
        .clk     (clk),
        .reset   (reset),
        .i_load  (w_load),
        .i_step  (w_step),
        .o_a     (w_a),
        .o_a_ovf (w_a_ovf)
    );

    // Next-state and engine control; abort wins over any other RUN/DONE action.
    always_comb begin
        w_next     = r_state;
        w_load     = 1'b0;
        w_step     = 1'b0;
        w_capture  = 1'b0;
        w_rsp_fire = 1'b0;
        case (r_state)
            IDLE: begin
                if (req_valid) begin
                    w_load = 1'b1;
                    w_next = RUN;
                end
            end
            RUN: begin
                if (abort) begin
                    w_next = IDLE;
                end else if (r_cnt == '0) begin
                    w_capture = 1'b1;
                    w_next    = DONE;
                end else begin
                    w_step = 1'b1;
                end
            end
            DONE: begin
                if (abort) begin
                    w_next = IDLE;
                end else if (rsp_ready) begin
                    w_rsp_fire = 1'b1;
                    w_next     = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // State, step counter, held response and completed-handshake counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_rsp_data   <= '0;
            r_rsp_ovf    <= 1'b0;
            r_done_count <= '0;
        end else begin
            r_state <= w_next;
            if (w_load) begin
                r_cnt <= req_index;
            end else if (w_step) begin
                r_cnt <= r_cnt - 1'b1;
            end
            if (w_capture) begin
                r_rsp_data <= w_a;
                r_rsp_ovf  <= w_a_ovf;
            end
            if (w_rsp_fire) begin
                r_done_count <= r_done_count + 1'b1;
            end
        end
    end

    assign req_ready    = (r_state == IDLE);
    assign rsp_valid    = (r_state == DONE);
    assign busy         = (r_state != IDLE);
    assign rsp_data     = r_rsp_data;
    assign rsp_overflow = r_rsp_ovf;
    assign done_count   = r_done_count;

endmodule

// File: tb/tb_fib_request_controller.sv
// Directed plus randomized bench for fib_request_controller.
module tb_fib_request_controller;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [7:0]  req_index;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_overflow;
    logic        abort;
    logic        busy;
    logic [15:0] done_count;

    int n_checks = 0;
    int n_err    = 0;
    int exp_done = 0;

    fib_request_controller dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_index    (req_index),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_data     (rsp_data),
        .rsp_overflow (rsp_overflow),
        .abort        (abort),
        .busy         (busy),
        .done_count   (done_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // F(n) mod 2^32 by plain modular iteration.
    function automatic logic [31:0] ref_data(input int n);
        logic [31:0] x = 32'd0;
        logic [31:0] y = 32'd1;
        logic [31:0] t;
        for (int i = 0; i < n; i++) begin
            t = x + y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    // True when exact F(n) does not fit in 32 bits (exact in 64 bits up to n=93).
    function automatic logic ref_ovf(input int n);
        longint unsigned x = 0;
        longint unsigned y = 1;
        longint unsigned t;
        if (n > 93) return 1'b1;
        for (int i = 0; i < n; i++) begin
            t = x + y;
            x = y;
            y = t;
        end
        return (x > 64'h0000_0000_FFFF_FFFF);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Present one request and return just after the accepting edge.
    task automatic send(input int n, input string tag);
        @(negedge clk);
        chk({tag, "_req_ready"}, {63'd0, req_ready}, 64'd1);
        req_valid = 1'b1;
        req_index = n[7:0];
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_index = 8'($urandom);
    endtask

    // Count edges until rsp_valid, bounded.
    task automatic wait_rsp(output int lat);
        lat = 0;
        while (rsp_valid !== 1'b1 && lat < 300) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic finish_rsp(input string tag);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        exp_done++;
        chk({tag, "_valid_clr"}, {63'd0, rsp_valid}, 64'd0);
        chk({tag, "_ready_back"}, {63'd0, req_ready}, 64'd1);
        chk({tag, "_done_count"}, {48'd0, done_count}, 64'(exp_done[15:0]));
    endtask

    task automatic run_req(input int n, input int hold, input string tag);
        int          lat;
        logic [31:0] d;
        send(n, tag);
        wait_rsp(lat);
        d = ref_data(n);
        chk({tag, "_latency"}, 64'(lat), 64'(n + 1));
        chk({tag, "_data"}, {32'd0, rsp_data}, {32'd0, d});
        chk({tag, "_ovf"}, {63'd0, rsp_overflow}, {63'd0, ref_ovf(n)});
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            chk({tag, "_hold_data"}, {32'd0, rsp_data}, {32'd0, d});
            chk({tag, "_hold_valid"}, {63'd0, rsp_valid}, 64'd1);
            chk({tag, "_hold_req_ready"}, {63'd0, req_ready}, 64'd0);
            chk({tag, "_hold_busy"}, {63'd0, busy}, 64'd1);
        end
        finish_rsp(tag);
    endtask

    initial begin
        int  lat;
        bit  seen;
        reset     = 1'b1;
        req_valid = 1'b0;
        req_index = 8'd0;
        rsp_ready = 1'b0;
        abort     = 1'b0;

        // Values while reset is held
        #12;
        chk("rst_req_ready", {63'd0, req_ready}, 64'd1);
        chk("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done_count", {48'd0, done_count}, 64'd0);
        chk("rst_rsp_data", {32'd0, rsp_data}, 64'd0);
        chk("rst_rsp_ovf", {63'd0, rsp_overflow}, 64'd0);
        @(negedge clk);
        reset = 1'b0;

        // Basic indices
        run_req(0, 0, "n0");
        run_req(1, 0, "n1");
        run_req(10, 0, "n10");
        chk("basic_done3", {48'd0, done_count}, 64'd3);

        // Overflow boundary, with fixed expected constants
        run_req(47, 0, "n47");
        chk("n47_const", {32'd0, rsp_data}, 64'd2971215073);
        run_req(48, 0, "n48");
        chk("n48_const", {32'd0, rsp_data}, 64'd512559680);
        chk("n48_ovf_const", {63'd0, rsp_overflow}, 64'd1);
        run_req(255, 0, "n255");

        // Backpressure
        run_req(7, 5, "bp7");

        // Abort mid-RUN
        send(20, "abort20");
        repeat (4) @(posedge clk);
        @(negedge clk);
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        chk("abort_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        chk("abort_req_ready", {63'd0, req_ready}, 64'd1);
        chk("abort_busy", {63'd0, busy}, 64'd0);
        chk("abort_done_count", {48'd0, done_count}, 64'(exp_done[15:0]));
        seen = 1'b0;
        repeat (25) begin
            @(posedge clk);
            #1;
            if (rsp_valid === 1'b1) seen = 1'b1;
        end
        chk("abort_no_rsp", {63'd0, seen}, 64'd0);
        run_req(5, 0, "after_abort5");

        // Abort coincident with response handshake
        send(4, "abort_hs");
        wait_rsp(lat);
        chk("abort_hs_data", {32'd0, rsp_data}, 64'd3);
        @(negedge clk);
        abort     = 1'b1;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        abort     = 1'b0;
        rsp_ready = 1'b0;
        chk("abort_hs_valid", {63'd0, rsp_valid}, 64'd0);
        chk("abort_hs_done", {48'd0, done_count}, 64'(exp_done[15:0]));
        chk("abort_hs_data_kept", {32'd0, rsp_data}, 64'd3);

        // Async reset mid-RUN, between edges
        send(30, "rst30");
        repeat (9) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        chk("midrst_busy", {63'd0, busy}, 64'd0);
        chk("midrst_req_ready", {63'd0, req_ready}, 64'd1);
        chk("midrst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        chk("midrst_done", {48'd0, done_count}, 64'd0);
        chk("midrst_data", {32'd0, rsp_data}, 64'd0);
        exp_done = 0;
        @(negedge clk);
        reset = 1'b0;
        run_req(3, 0, "after_rst3");

        // req_index changes during RUN are ignored (send randomizes it)
        run_req(12, 1, "n12");
        chk("n12_const", {32'd0, rsp_data}, 64'd144);

        // req_valid held through DONE
        @(negedge clk);
        req_valid = 1'b1;
        req_index = 8'd2;
        @(posedge clk);
        #1;
        req_index = 8'd9;
        wait_rsp(lat);
        chk("hold_lat", 64'(lat), 64'd3);
        chk("hold_data", {32'd0, rsp_data}, 64'd1);
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("hold_req_ready_done", {63'd0, req_ready}, 64'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        exp_done++;
        chk("hold_hs_idle", {63'd0, req_ready}, 64'd1);
        chk("hold_hs_done", {48'd0, done_count}, 64'(exp_done[15:0]));
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        chk("hold_accept_next", {63'd0, busy}, 64'd1);
        wait_rsp(lat);
        chk("hold2_lat", 64'(lat), 64'd10);
        chk("hold2_data", {32'd0, rsp_data}, 64'd34);
        finish_rsp("hold2");

        // Randomized indices and backpressure against the model
        for (int i = 0; i < 8; i++) begin
            run_req(int'($urandom_range(0, 255)), int'($urandom_range(0, 3)), "rand");
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
